// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding for alu_multicycle
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_LUI   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier and restoring divider
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // opnd is the multiplicand or the divisor; acc_lo holds product low bits or
    // the dividend that shifts out MSB first while quotient bits shift in.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] count;
    logic             div_mode;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;

    // Result of the current iteration; the top registers it on the final edge
    always_comb begin
        sum     = '0;
        shifted = '0;
        hi_next = acc_hi;
        lo_next = acc_lo;
        if (div_mode) begin
            shifted = {acc_hi, acc_lo[WIDTH-1]};
            if (shifted >= {1'b0, opnd}) begin
                sum     = shifted - {1'b0, opnd};
                hi_next = sum[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add becomes the new MSB after the right shift
            sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign last = (count == '0);

    // Operand latch on load, then one iteration per cycle while stepping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opnd     <= '0;
            mplier   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            count    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= is_div;
            count    <= CNT_W'(WIDTH - 1);
            acc_hi   <= '0;
            if (is_div) begin
                opnd   <= b;
                mplier <= '0;
                acc_lo <= a;
            end else begin
                opnd   <= a;
                mplier <= b;
                acc_lo <= '0;
            end
        end else if (step) begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with handshake and iterative MULTU/DIVU
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic [WIDTH-1:0]   ALUResultHi,
    output logic               Zero,
    output logic               Overflow,
    output logic               DivZero
);

    localparam int MSB = WIDTH - 1;

    state_t           state;
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_dz;
    logic             is_long;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign sum_ab  = A + B;
    assign diff_ab = A - B;

    // Divide by zero is resolved in one cycle, so only nonzero DIVU goes iterative
    assign is_long = (ALUOperation == OP_MULTU) ||
                     ((ALUOperation == OP_DIVU) && (B != '0));
    assign md_load = (state == ST_IDLE) && start && is_long;
    assign md_step = (state != ST_IDLE);

    mul_div_unit #(
        .WIDTH (WIDTH)
    ) u_mul_div (
        .clk     (clk),
        .reset   (reset),
        .load    (md_load),
        .is_div  (ALUOperation == OP_DIVU),
        .step    (md_step),
        .a       (A),
        .b       (B),
        .hi_next (md_hi),
        .lo_next (md_lo),
        .last    (md_last)
    );

    // Single-cycle operations and the DIVU-by-zero result
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_ovf    = 1'b0;
        sc_dz     = 1'b0;
        case (ALUOperation)
            OP_AND: sc_result = A & B;
            OP_OR:  sc_result = A | B;
            OP_ADD: begin
                sc_result = sum_ab;
                sc_ovf    = (A[MSB] == B[MSB]) && (sum_ab[MSB] != A[MSB]);
            end
            OP_SUB: begin
                sc_result = diff_ab;
                sc_ovf    = (A[MSB] == ~B[MSB]) && (diff_ab[MSB] != A[MSB]);
            end
            OP_LUI: sc_result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_NOR: sc_result = ~(A | B);
            OP_SLL: sc_result = A << shamt;
            OP_SRL: sc_result = A >> shamt;
            OP_SRA: sc_result = $unsigned($signed(A) >>> shamt);
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_DIVU: begin
                if (B == '0) begin
                    sc_result = '1;
                    sc_hi     = A;
                    sc_dz     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            ALUResult   <= '0;
            ALUResultHi <= '0;
            Zero        <= 1'b1;
            Overflow    <= 1'b0;
            DivZero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            state <= (ALUOperation == OP_MULTU) ? ST_MUL : ST_DIV;
                            ready <= 1'b0;
                        end else begin
                            ALUResult   <= sc_result;
                            ALUResultHi <= sc_hi;
                            Zero        <= (sc_result == '0);
                            Overflow    <= sc_ovf;
                            DivZero     <= sc_dz;
                            done        <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_last) begin
                        ALUResult   <= md_lo;
                        ALUResultHi <= md_hi;
                        Zero        <= (md_lo == '0);
                        Overflow    <= 1'b0;
                        DivZero     <= 1'b0;
                        done        <= 1'b1;
                        ready       <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  sh = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        dz;
        bit          long_op;
    } exp_t;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (op),
        .A            (a),
        .B            (b),
        .shamt        (sh),
        .ready        (ready),
        .done         (done),
        .ALUResult    (result),
        .ALUResultHi  (result_hi),
        .Zero         (zero),
        .Overflow     (overflow),
        .DivZero      (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on wide signed/unsigned values
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] s);
        exp_t            e;
        longint          sx;
        longint          sy;
        longint          t;
        longint unsigned p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.long_op = 1'b0;
        case (o)
            4'd0:  e.lo = x & y;
            4'd1:  e.lo = x | y;
            4'd2:  begin t = sx + sy; e.lo = t[31:0]; e.ovf = (t != longint'($signed(t[31:0]))); end
            4'd3:  begin t = sx - sy; e.lo = t[31:0]; e.ovf = (t != longint'($signed(t[31:0]))); end
            4'd4:  e.lo = (y & 32'h0000_FFFF) * 32'd65536;
            4'd5:  e.lo = ~(x | y);
            4'd6:  e.lo = x << s;
            4'd7:  e.lo = x >> s;
            4'd8:  begin t = sx >>> s; e.lo = t[31:0]; end
            4'd9:  e.lo = (sx < sy) ? 32'd1 : 32'd0;
            4'd10: begin
                p = longint'(x) * longint'(y);
                e.lo = p[31:0]; e.hi = p[63:32]; e.long_op = 1'b1;
            end
            4'd11: begin
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y; e.long_op = 1'b1;
                end
            end
            default: ;
        endcase
        e.zero = (e.lo == 0);
        return e;
    endfunction

    task automatic check_outputs(input exp_t e);
        check("result", result, e.lo);
        check("result_hi", result_hi, e.hi);
        check("zero", zero, e.zero);
        check("overflow", overflow, e.ovf);
        check("div_zero", div_zero, e.dz);
    endtask

    // Issue one op from idle, wait (bounded) for done, check latency and outputs
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s, input bit poke);
        exp_t e;
        int   lat;
        int   low;
        e = model(o, x, y, s);
        op = o; a = x; b = y; sh = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        low = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (ready === 1'b0) low++;
            if (poke && lat == 5) begin
                start = 1'b1; op = OP_AND; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, e.long_op ? 33 : 1);
        check("ready_low_cycles", low, e.long_op ? 32 : 0);
        check("ready_at_done", ready, 1'b1);
        check_outputs(e);
        @(negedge clk);
        check("done_single_pulse", done, 1'b0);
        check("result_hold", result, e.lo);
    endtask

    initial begin
        exp_t e;
        int   dones;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_result_hi", result_hi, 32'h0);
        check("rst_zero", zero, 1'b1);
        check("rst_overflow", overflow, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_done", done, 1'b0);

        // Back-to-back single-cycle ops
        op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h1; sh = '0; start = 1'b1;
        @(negedge clk);
        check("b2b_add_done", done, 1'b1);
        check("b2b_add_result", result, 32'h8000_0000);
        check("b2b_add_ovf", overflow, 1'b1);
        op = OP_SUB; a = 32'd5; b = 32'd5;
        @(negedge clk);
        check("b2b_sub_done", done, 1'b1);
        check("b2b_sub_result", result, 32'h0);
        check("b2b_sub_zero", zero, 1'b1);
        check("b2b_sub_ovf", overflow, 1'b0);
        op = OP_SRA; a = 32'h8000_0000; b = '0; sh = 5'd4;
        @(negedge clk);
        check("b2b_sra_done", done, 1'b1);
        check("b2b_sra_result", result, 32'hF800_0000);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_drop", done, 1'b0);

        // Directed long and boundary operations
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        check("multu_max_hi", result_hi, 32'hFFFF_FFFE);
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0);
        check("divu_quot", result, 32'd14);
        check("divu_rem", result_hi, 32'd2);
        run_op(OP_DIVU, 32'd9, 32'd0, 5'd0, 1'b0);
        run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b1);
        run_op(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 1'b0);
        run_op(OP_LUI, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);

        // Reset mid-DIVU aborts immediately and produces no done
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 32'h0);
        check("abort_result_hi", result_hi, 32'h0);
        check("abort_zero", zero, 1'b1);
        check("abort_div_zero", div_zero, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(OP_ADD, 32'd20, 32'd22, 5'd0, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (ro == OP_DIVU && $urandom_range(0, 1) == 1) rb = rb & 32'h0000_00FF;
            if (ro == OP_ADD && $urandom_range(0, 1) == 1) rb = ra;
            run_op(ro, ra, rb, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
